// File: rtl/alu_multicycle_if.sv
// Handshake bus for alu_multicycle: operand/op input channel and result output channel.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [1:0]       flags;
  logic             div_zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags, div_zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags, div_zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic ops, iterative shift-add MUL and
// restoring DIV, valid/ready handshake on both sides.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  alu_multicycle_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
    OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_NOT = 3'b111
  } op_t;

  state_t           state, state_nx;
  op_t              op_r;
  op_t              op_in;
  logic [WIDTH-1:0] acc, opnd, shreg;
  logic [WIDTH-1:0] acc_nx, opnd_nx, shreg_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_r;
  logic [1:0]       flags_r;
  logic             dz_r;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH-1:0] long_res;
  logic             is_long;
  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign op_in     = op_t'(bus.op);
  assign accept    = bus.in_valid && (state == S_IDLE);
  assign last_iter = (cnt == CNT_W'(1));
  assign is_long   = (op_in == OP_MUL) || ((op_in == OP_DIV) && (bus.b != '0));

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
  assign bus.div_zero  = dz_r;

  // Single-cycle result for ops that finish at accept (DIV here only when b==0)
  always_comb begin
    fast_res = '0;
    unique case (op_in)
      OP_ADD:  fast_res = bus.a + bus.b;
      OP_SUB:  fast_res = bus.a - bus.b;
      OP_AND:  fast_res = bus.a & bus.b;
      OP_OR:   fast_res = bus.a | bus.b;
      OP_XOR:  fast_res = bus.a ^ bus.b;
      OP_NOT:  fast_res = ~bus.a;
      OP_DIV:  fast_res = '1;
      default: fast_res = '0;
    endcase
  end

  // One iteration of the shared datapath.
  // MUL: acc = partial product, opnd = shifted multiplicand, shreg = multiplier.
  // DIV: acc = partial remainder, opnd = divisor, shreg = dividend bits shifting
  //      out the top while quotient bits shift in at the bottom.
  always_comb begin
    acc_nx   = acc;
    opnd_nx  = opnd;
    shreg_nx = shreg;
    rem_sh   = {acc, shreg[WIDTH-1]};
    diff     = rem_sh - {1'b0, opnd};
    if (op_r == OP_MUL) begin
      acc_nx   = acc + (shreg[0] ? opnd : '0);
      opnd_nx  = opnd << 1;
      shreg_nx = shreg >> 1;
    end else if (!diff[WIDTH]) begin
      acc_nx   = diff[WIDTH-1:0];
      shreg_nx = {shreg[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx   = rem_sh[WIDTH-1:0];
      shreg_nx = {shreg[WIDTH-2:0], 1'b0};
    end
    long_res = (op_r == OP_MUL) ? acc_nx : shreg_nx;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = is_long ? S_BUSY : S_DONE;
      S_BUSY: if (last_iter) state_nx = S_DONE;
      S_DONE: if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latch, iteration registers and result/flags registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= OP_ADD;
      acc      <= '0;
      opnd     <= '0;
      shreg    <= '0;
      cnt      <= '0;
      result_r <= '0;
      flags_r  <= '0;
      dz_r     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          op_r <= op_in;
          if (is_long) begin
            cnt   <= CNT_W'(WIDTH);
            acc   <= '0;
            opnd  <= (op_in == OP_MUL) ? bus.a : bus.b;
            shreg <= (op_in == OP_MUL) ? bus.b : bus.a;
            dz_r  <= 1'b0;
          end else begin
            result_r <= fast_res;
            flags_r  <= {fast_res[WIDTH-1], fast_res == '0};
            dz_r     <= (op_in == OP_DIV);
          end
        end
        S_BUSY: begin
          acc   <= acc_nx;
          opnd  <= opnd_nx;
          shreg <= shreg_nx;
          cnt   <= cnt - CNT_W'(1);
          if (last_iter) begin
            result_r <= long_res;
            flags_r  <= {long_res[WIDTH-1], long_res == '0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one op in IDLE; return cycles from accept to out_valid and
  // number of sampled cycles with in_ready low before out_valid.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int busy);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~x;
    bus.b = ~y;
    bus.op = ~o;
    lat = 1;
    busy = 0;
    while (!bus.out_valid && lat < 100) begin
      if (!bus.in_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset.out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset.in_ready got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.result !== 32'h0) $display("FAIL reset.result got %h want 0", bus.result); else passed++;
    total++; if (bus.flags !== 2'b00) $display("FAIL reset.flags got %b want 00", bus.flags); else passed++;
    total++; if (bus.div_zero !== 1'b0) $display("FAIL reset.div_zero got %b want 0", bus.div_zero); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_wrap();
    int lat, busy;
    do_op(3'b000, 32'hFFFF_FFFF, 32'h1, lat, busy);
    total++; if (lat !== 1) $display("FAIL add.latency got %0d want 1", lat); else passed++;
    total++; if (busy !== 0) $display("FAIL add.busy got %0d want 0", busy); else passed++;
    total++; if (bus.result !== 32'h0) $display("FAIL add.result got %h want 0", bus.result); else passed++;
    total++; if (bus.flags !== 2'b01) $display("FAIL add.flags got %b want 01", bus.flags); else passed++;
    total++; if (bus.div_zero !== 1'b0) $display("FAIL add.div_zero got %b want 0", bus.div_zero); else passed++;
    consume();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL add.out_valid_after got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL add.in_ready_after got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_single_cycle_ops();
    int lat, busy;
    do_op(3'b001, 32'd5, 32'd7, lat, busy);
    total++; if (bus.result !== 32'hFFFF_FFFE) $display("FAIL sub.result got %h want fffffffe", bus.result); else passed++;
    total++; if (bus.flags !== 2'b10) $display("FAIL sub.flags got %b want 10", bus.flags); else passed++;
    total++; if (lat !== 1) $display("FAIL sub.latency got %0d want 1", lat); else passed++;
    consume();
    do_op(3'b111, 32'h0, 32'h1234, lat, busy);
    total++; if (bus.result !== 32'hFFFF_FFFF) $display("FAIL not.result got %h want ffffffff", bus.result); else passed++;
    total++; if (bus.flags !== 2'b10) $display("FAIL not.flags got %b want 10", bus.flags); else passed++;
    consume();
    do_op(3'b100, 32'hF0F0_1234, 32'h0FF0_FF00, lat, busy);
    total++; if (bus.result !== 32'h00F0_1200) $display("FAIL and.result got %h want 00f01200", bus.result); else passed++;
    total++; if (bus.flags !== 2'b00) $display("FAIL and.flags got %b want 00", bus.flags); else passed++;
    consume();
    do_op(3'b101, 32'hA0, 32'h05, lat, busy);
    total++; if (bus.result !== 32'hA5) $display("FAIL or.result got %h want a5", bus.result); else passed++;
    consume();
    do_op(3'b110, 32'h5, 32'h5, lat, busy);
    total++; if (bus.result !== 32'h0) $display("FAIL xor.result got %h want 0", bus.result); else passed++;
    total++; if (bus.flags !== 2'b01) $display("FAIL xor.flags got %b want 01", bus.flags); else passed++;
    consume();
  endtask

  task automatic test_mul();
    int lat, busy;
    do_op(3'b010, 32'd1234, 32'd5678, lat, busy);
    total++; if (lat !== 33) $display("FAIL mul.latency got %0d want 33", lat); else passed++;
    total++; if (busy !== 32) $display("FAIL mul.busy got %0d want 32", busy); else passed++;
    total++; if (bus.result !== 32'd7006652) $display("FAIL mul.result got %0d want 7006652", bus.result); else passed++;
    total++; if (bus.flags !== 2'b00) $display("FAIL mul.flags got %b want 00", bus.flags); else passed++;
    total++; if (bus.div_zero !== 1'b0) $display("FAIL mul.div_zero got %b want 0", bus.div_zero); else passed++;
    consume();
    do_op(3'b010, 32'h0001_0000, 32'h0001_0000, lat, busy);
    total++; if (bus.result !== 32'h0) $display("FAIL mul_wrap.result got %h want 0", bus.result); else passed++;
    total++; if (bus.flags !== 2'b01) $display("FAIL mul_wrap.flags got %b want 01", bus.flags); else passed++;
    consume();
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, lat, busy);
    total++; if (bus.result !== 32'hFFFF_FFFE) $display("FAIL mul_max.result got %h want fffffffe", bus.result); else passed++;
    total++; if (bus.flags !== 2'b10) $display("FAIL mul_max.flags got %b want 10", bus.flags); else passed++;
    consume();
  endtask

  task automatic test_div();
    int lat, busy;
    do_op(3'b011, 32'd100, 32'd7, lat, busy);
    total++; if (bus.result !== 32'd14) $display("FAIL div.result got %0d want 14", bus.result); else passed++;
    total++; if (lat !== 33) $display("FAIL div.latency got %0d want 33", lat); else passed++;
    total++; if (bus.div_zero !== 1'b0) $display("FAIL div.div_zero got %b want 0", bus.div_zero); else passed++;
    consume();
    do_op(3'b011, 32'd9, 32'd0, lat, busy);
    total++; if (bus.result !== 32'hFFFF_FFFF) $display("FAIL div0.result got %h want ffffffff", bus.result); else passed++;
    total++; if (bus.div_zero !== 1'b1) $display("FAIL div0.div_zero got %b want 1", bus.div_zero); else passed++;
    total++; if (lat !== 1) $display("FAIL div0.latency got %0d want 1", lat); else passed++;
    total++; if (bus.flags !== 2'b10) $display("FAIL div0.flags got %b want 10", bus.flags); else passed++;
    consume();
    do_op(3'b011, 32'hFFFF_FFFF, 32'd1, lat, busy);
    total++; if (bus.result !== 32'hFFFF_FFFF) $display("FAIL div_by1.result got %h want ffffffff", bus.result); else passed++;
    total++; if (bus.div_zero !== 1'b0) $display("FAIL div_by1.div_zero got %b want 0", bus.div_zero); else passed++;
    consume();
    do_op(3'b011, 32'd7, 32'd100, lat, busy);
    total++; if (bus.result !== 32'd0) $display("FAIL div_small.result got %0d want 0", bus.result); else passed++;
    total++; if (bus.flags !== 2'b01) $display("FAIL div_small.flags got %b want 01", bus.flags); else passed++;
    consume();
    do_op(3'b011, 32'hDEAD_BEEF, 32'h0001_0000, lat, busy);
    total++; if (bus.result !== 32'h0000_DEAD) $display("FAIL div_shift.result got %h want 0000dead", bus.result); else passed++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat, busy;
    bus.out_ready = 1'b0;
    do_op(3'b010, 32'd3, 32'd4, lat, busy);
    total++; if (lat !== 33) $display("FAIL bp.latency got %0d want 33", lat); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 3'b000;
      bus.a = 32'd1;
      bus.b = 32'd1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1) $display("FAIL bp.hold_valid[%0d] got %b want 1", i, bus.out_valid); else passed++;
      total++; if (bus.result !== 32'd12) $display("FAIL bp.hold_result[%0d] got %0d want 12", i, bus.result); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL bp.in_ready[%0d] got %b want 0", i, bus.in_ready); else passed++;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp.release_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp.release_ready got %b want 1", bus.in_ready); else passed++;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp.no_accept got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_reset_mid_div();
    int lat, busy;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 3'b011;
    bus.a = 32'd100;
    bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid.out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_mid.in_ready got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.result !== 32'h0) $display("FAIL rst_mid.result got %h want 0", bus.result); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid.dropped got %b want 0", bus.out_valid); else passed++;
    do_op(3'b000, 32'd2, 32'd3, lat, busy);
    total++; if (bus.result !== 32'd5) $display("FAIL rst_mid.add_result got %0d want 5", bus.result); else passed++;
    total++; if (lat !== 1) $display("FAIL rst_mid.add_latency got %0d want 1", lat); else passed++;
    consume();
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_wrap();
    test_single_cycle_ops();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
